sum_accumulator: RTL

//   Downstream consumer of the 6-bit adder's 7-bit sum. Accepts a stream of sums on a

---
 rtl/sum_accumulator_pkg.sv | 16 +
 rtl/sum_accumulator_if.sv | 30 +++
 rtl/sum_accumulator_sat_add.sv | 25 ++
 rtl/sum_accumulator.sv | 102 ++++++++++
 4 files changed

// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum_accumulator block: FSM state encoding and
// default widths used by the interface, the adder and the top level.
package sum_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned SUM_W_DEF = 7;
    localparam int unsigned ACC_W_DEF = 12;
    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned BATCH_DEF = 8;

endpackage

// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder6 sum source, the accumulator and the
// result sink; master drives samples and takes results, slave is the block.
interface sum_accumulator_if
    import sum_accumulator_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, clear, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, clear, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );

endinterface

// File: rtl/sum_accumulator_sat_add.sv
// Combinational W-bit unsigned add returning sum and carry-out.
// With SUM_ACCUMULATOR_SAT_EN defined the sum clamps to all-ones on carry.
module sat_add
    import sum_accumulator_pkg::*;
#(
    parameter int unsigned W = ACC_W_DEF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);
    logic [W:0] raw;

    always_comb begin
        raw     = {1'b0, a_i} + {1'b0, b_i};
        carry_o = raw[W];
`ifdef SUM_ACCUMULATOR_SAT_EN
        sum_o   = raw[W] ? '1 : raw[W-1:0];
`else
        sum_o   = raw[W-1:0];
`endif
    end

endmodule

// File: rtl/sum_accumulator.sv
// Batch accumulator: sums BATCH accepted samples and holds the total until
// taken. Optional clamp-on-overflow via SUM_ACCUMULATOR_SAT_EN (see sat_add).
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned BATCH = BATCH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst_n,
    sum_accumulator_if.slave bus
);
    localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             carry;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;
    logic [ACC_W-1:0] sum_ext;

    assign sum_ext = {{(ACC_W - SUM_W){1'b0}}, bus.in_sum};
    assign accept  = bus.in_valid & in_ready_q;
    assign cnt_d   = cnt_q + 1'b1;

    sat_add #(.W(ACC_W)) u_add (
        .a_i     (acc_q),
        .b_i     (sum_ext),
        .sum_o   (acc_d),
        .carry_o (carry)
    );

    // IDLE and ACCUM share the accept path: acc is already zero in IDLE, so
    // the first sample lands as acc=in_sum and BATCH=1 goes straight to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_q | carry;
                        if (cnt_d == BATCH_C) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;

endmodule
